// File: rtl/rf_writeback_unit.sv
// Register-file writeback: merges ALU results and load responses onto one write port (latency 1),
// tracks outstanding load destinations for hazards/WAW, and stalls execute via ex_ready_o.
module rf_writeback_unit #(
  parameter int LoadDepth = 2,
  parameter int DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ex_valid_i,
  input  logic                 ex_is_load_i,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  output logic                 ex_ready_o,
  input  logic                 lsu_resp_valid_i,
  input  logic [DataWidth-1:0] lsu_rdata_i,
  input  logic                 lsu_err_i,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  output logic                 hazard_o,
  output logic                 fwd_a_o,
  output logic                 fwd_b_o,
  output logic                 load_err_o,
  output logic [4:0]           load_err_addr_o,
  output logic [2:0]           pending_cnt_o
);

  localparam int PtrW = (LoadDepth > 2) ? 2 : 1;

  logic [4:0]           mem_q [LoadDepth];
  logic [4:0]           mem_d [LoadDepth];
  logic [PtrW-1:0]      wptr_q, wptr_d;
  logic [PtrW-1:0]      rptr_q, rptr_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 rf_we_q, rf_we_d;
  logic [4:0]           rf_waddr_q, rf_waddr_d;
  logic [DataWidth-1:0] rf_wdata_q, rf_wdata_d;
  logic                 err_q, err_d;
  logic [4:0]           err_addr_q, err_addr_d;

  logic [LoadDepth-1:0] ent_vld;
  logic                 hit_w, hit_a, hit_b;
  logic                 full, pop, push, alu_acc;
  logic [4:0]           head;
  int                   idx;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(LoadDepth - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  // Occupied slots run from the read pointer for cnt_q entries, wrapping.
  always_comb begin
    ent_vld = '0;
    idx     = 0;
    for (int k = 0; k < LoadDepth; k++) begin
      idx = (int'(rptr_q) + k) % LoadDepth;
      if (k < int'(cnt_q)) begin
        ent_vld[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    hit_w = 1'b0;
    hit_a = 1'b0;
    hit_b = 1'b0;
    for (int i = 0; i < LoadDepth; i++) begin
      if (ent_vld[i] && (mem_q[i] == ex_waddr_i)) hit_w = 1'b1;
      if (ent_vld[i] && (mem_q[i] == raddr_a_i))  hit_a = 1'b1;
      if (ent_vld[i] && (mem_q[i] == raddr_b_i))  hit_b = 1'b1;
    end
  end

  assign head = mem_q[rptr_q];
  assign full = (cnt_q == 3'(LoadDepth));
  assign pop  = lsu_resp_valid_i && (cnt_q != 3'd0);

  always_comb begin
    if (ex_is_load_i) begin
      ex_ready_o = !(full && !pop);
    end else begin
      ex_ready_o = !lsu_resp_valid_i && !((ex_waddr_i != 5'd0) && hit_w);
    end
  end

  assign push    = ex_valid_i && ex_is_load_i && ex_ready_o;
  assign alu_acc = ex_valid_i && !ex_is_load_i && ex_ready_o;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      mem_d[wptr_q] = ex_waddr_i;
      wptr_d        = ptr_inc(wptr_q);
    end
    if (pop) begin
      rptr_d = ptr_inc(rptr_q);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Address/data hold their last value whenever no write source is accepted.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    err_d      = 1'b0;
    err_addr_d = 5'd0;
    if (pop) begin
      if (lsu_err_i) begin
        err_d      = 1'b1;
        err_addr_d = head;
      end else begin
        rf_we_d    = (head != 5'd0);
        rf_waddr_d = head;
        rf_wdata_d = lsu_rdata_i;
      end
    end else if (alu_acc) begin
      rf_we_d    = (ex_waddr_i != 5'd0);
      rf_waddr_d = ex_waddr_i;
      rf_wdata_d = ex_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LoadDepth; i++) begin
        mem_q[i] <= 5'd0;
      end
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= 3'd0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= '0;
      err_q      <= 1'b0;
      err_addr_q <= 5'd0;
    end else begin
      mem_q      <= mem_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign rf_we_o         = rf_we_q;
  assign rf_waddr_o      = rf_waddr_q;
  assign rf_wdata_o      = rf_wdata_q;
  assign load_err_o      = err_q;
  assign load_err_addr_o = err_addr_q;
  assign pending_cnt_o   = cnt_q;

  // Hazard includes the entry popped this cycle: its data is not in the RF yet.
  assign hazard_o = ((raddr_a_i != 5'd0) && hit_a) || ((raddr_b_i != 5'd0) && hit_b);
  assign fwd_a_o  = rf_we_q && (rf_waddr_q == raddr_a_i) && (raddr_a_i != 5'd0);
  assign fwd_b_o  = rf_we_q && (rf_waddr_q == raddr_b_i) && (raddr_b_i != 5'd0);

endmodule

// File: doc/rf_writeback_unit.md
RF_WRITEBACK_UNIT -- requirements
Module: rf_writeback_unit

Interface
REQ-001 SHALL have parameter LoadDepth, default 2, meaning the maximum number of outstanding loads (legal range 2..4).
REQ-002 SHALL have parameter DataWidth, default 32, meaning the write data width.
REQ-003 clk_i  input  1  clock; all state updates on the rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 ex_valid_i  input  1  execute stage presents a result or a load issue.
REQ-006 ex_is_load_i  input  1  1 means load issue (destination only, no data); 0 means ALU result.
REQ-007 ex_waddr_i  input  5  destination register.
REQ-008 ex_wdata_i  input  DataWidth  ALU result; ignored for loads.
REQ-009 ex_ready_o  output  1  the execute request is accepted this cycle.
REQ-010 lsu_resp_valid_i  input  1  load response present; always accepted.
REQ-011 lsu_rdata_i  input  DataWidth  load data.
REQ-012 lsu_err_i  input  1  load response carries a bus error.
REQ-013 rf_we_o, rf_waddr_o, rf_wdata_o  output  1/5/DataWidth  registered register-file write port.
REQ-014 raddr_a_i, raddr_b_i  input  5  decode-stage source addresses.
REQ-015 hazard_o  output  1  a source depends on an outstanding load.
REQ-016 fwd_a_o, fwd_b_o  output  1  forward rf_wdata_o to operand A or B.
REQ-017 load_err_o  output  1  one-cycle error pulse.
REQ-018 load_err_addr_o  output  5  destination of the errored load.
REQ-019 pending_cnt_o  output  3  number of outstanding loads.

Function
REQ-020 Pending FIFO: SHALL hold LoadDepth 5-bit destination entries with read/write pointers wrapping modulo LoadDepth and a count from 0 to LoadDepth.
REQ-021 Accept rule: ex_ready_o SHALL be 1 unless one of these holds:
- (a) load issue while the FIFO is full and no pop occurs this cycle;
- (b) ALU request while lsu_resp_valid_i=1 (the response owns the write port);
- (c) ALU request whose non-zero ex_waddr_i matches any valid pending entry (WAW ordering).
REQ-022 ex_ready_o SHALL be computed combinationally from the current inputs and state.
REQ-023 Accepted load issue: SHALL push ex_waddr_i, including x0, and produce no write.
REQ-024 Accepted ALU request: SHALL register rf_we_o=(ex_waddr_i!=0), rf_waddr_o and rf_wdata_o on the next edge (latency 1).
REQ-025 Load response with the FIFO non-empty: SHALL pop the head entry.
- lsu_err_i=0: next cycle rf_we_o=(head!=0), rf_waddr_o=head, rf_wdata_o=lsu_rdata_i.
- lsu_err_i=1: rf_we_o=0; load_err_o=1 and load_err_addr_o=head for one cycle.
REQ-026 Load response with the FIFO empty: SHALL be ignored, with no write, no pop and no error pulse.
REQ-027 Push and pop in the same cycle: SHALL both occur, leaving the count unchanged; a full FIFO SHALL accept a push when a pop occurs in the same cycle.
REQ-028 No accepted write source in a cycle: rf_we_o SHALL be 0 the next cycle; rf_waddr_o and rf_wdata_o SHALL hold their previous values.
REQ-029 hazard_o SHALL be 1 when raddr_a_i or raddr_b_i is non-zero and equals any valid pending entry, including the entry being popped this cycle.
REQ-030 fwd_a_o SHALL equal rf_we_o & (rf_waddr_o==raddr_a_i) & (raddr_a_i!=0); fwd_b_o likewise for raddr_b_i.
REQ-031 pending_cnt_o SHALL equal the registered FIFO count.

Reset
REQ-032 While rst_ni=0, all of the following SHALL be 0: rf_we_o, rf_waddr_o, rf_wdata_o, load_err_o, load_err_addr_o, pending_cnt_o, and both FIFO pointers.
REQ-033 Reset asserted mid-operation SHALL discard all pending entries; responses arriving after reset release SHALL follow REQ-026.
REQ-034 Outputs derived from FIFO state (hazard_o, fwd_a_o, fwd_b_o) SHALL be 0 during reset.

Verification
REQ-035 ALU request: ex waddr=5, wdata=0xDEADBEEF -> next cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF; with raddr_a_i=5, fwd_a_o=1.
REQ-036 Load chain: load to x7, then load to x9 (count=2).
- Third load -> ex_ready_o=0.
- Response 0x11 -> write x7=0x11 and count=1.
- With raddr_b_i=9, hazard_o=1 until the second response.
REQ-037 Simultaneous load response (0x22, dest x3) and ALU request to x4 -> ex_ready_o=0 and x3=0x22 is written; the ALU write to x4 occurs one cycle later.
REQ-038 WAW: pending load to x6 and ALU request to x6 -> ex_ready_o=0 until the response is written; then the ALU value lands, so the final x6 holds the ALU value.
REQ-039 Load to x0 with response 0x55 -> pop, rf_we_o=0; separately, an errored load to x12 -> load_err_o pulse with load_err_addr_o=12 and no write.
REQ-040 Two loads pending, then reset -> count=0 and hazard_o=0; a stray response after reset -> no write.
